// File: rtl/minmax_pkg.sv
// Shared constants and types for the min/max frame tracker.
// State encoding and data width used by the top and comparator.
package minmax_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_16b_str.sv
// Unsigned 16-bit magnitude comparator.
// Purely combinational; feeds the min/max register enables.
module cmp_16b_str
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_is_smaller,
    output logic              a_is_greater,
    output logic              a_is_equal
);

    // Unsigned compare of a against b
    always_comb begin
        a_is_smaller = (a < b);
        a_is_greater = (a > b);
        a_is_equal   = (a == b);
    end

endmodule

// File: rtl/minmax_tracker_16b.sv
// Streaming per-frame min/max/count tracker.
// Result is registered and held until the consumer takes it.
module minmax_tracker_16b
    import minmax_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W-1:0]  omin_q, omin_d;
    logic [DATA_W-1:0]  omax_q, omax_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               oovf_q, oovf_d;

    logic accept;
    logic lt_min, gt_max;
    logic eq_min, eq_max;

    cmp_16b_str u_cmp_min (
        .a            (in_data),
        .b            (min_q),
        .a_is_smaller (lt_min),
        .a_is_greater (),
        .a_is_equal   (eq_min)
    );

    cmp_16b_str u_cmp_max (
        .a            (in_data),
        .b            (max_q),
        .a_is_smaller (),
        .a_is_greater (gt_max),
        .a_is_equal   (eq_max)
    );

    assign accept = in_valid && in_ready_q;

    // Next-state, accumulator update and result capture
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? ST_REPORT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (lt_min) min_d = in_data;
                    if (gt_max) max_d = in_data;
                    if (&cnt_q) ovf_d = 1'b1;
                    else        cnt_d = cnt_q + CNT_W'(1);
                    state_d = in_last ? ST_REPORT : ST_ACCUM;
                end
            end
            ST_REPORT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs only move on the edge that takes the last sample
        if (accept && in_last) begin
            omin_d = min_d;
            omax_d = max_d;
            ocnt_d = cnt_d;
            oovf_d = ovf_d;
        end else begin
            omin_d = omin_q;
            omax_d = omax_q;
            ocnt_d = ocnt_q;
            oovf_d = oovf_q;
        end

        in_ready_d  = (state_d != ST_REPORT);
        out_valid_d = (state_d == ST_REPORT);
    end

    // FSM, accumulators and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            omin_q      <= '0;
            omax_q      <= '0;
            ocnt_q      <= '0;
            oovf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            omin_q      <= omin_d;
            omax_q      <= omax_d;
            ocnt_q      <= ocnt_d;
            oovf_q      <= oovf_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_min      = omin_q;
    assign out_max      = omax_q;
    assign out_count    = ocnt_q;
    assign out_overflow = oovf_q;

endmodule
